// File: rtl/cla32_pipe.sv
// Two-stage pipelined 32-bit adder: low half in stage 1, high half in stage 2.
// Each 16-bit half is four cla4 blocks joined by group lookahead.

module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       pg,
  output logic       gg
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c;
  assign pg = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);
  logic [3:0] pg;
  logic [3:0] gg;
  logic [3:0] gc;

  // Group carries come straight from the block PG/GG terms, never rippled.
  assign gc[0] = ci;
  assign gc[1] = gg[0] | (pg[0] & ci);
  assign gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & ci);
  assign gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
               | (pg[2] & pg[1] & pg[0] & ci);
  assign co    = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
               | (pg[3] & pg[2] & pg[1] & gg[0])
               | (pg[3] & pg[2] & pg[1] & pg[0] & ci);

  for (genvar i = 0; i < 4; i++) begin : g_blk
    cla4 u_cla4 (
      .a  (a[4*i +: 4]),
      .b  (b[4*i +: 4]),
      .ci (gc[i]),
      .s  (s[4*i +: 4]),
      .pg (pg[i]),
      .gg (gg[i])
    );
  end
endmodule

module cla32_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum,
  output logic        co,
  output logic        ovf
);
  // Handshake: a beat moves on a rising edge where valid && ready. The producer
  // holds a/b/ci while in_valid && !in_ready; sum/co/ovf hold while
  // out_valid && !out_ready. in_ready depends only on stage state and out_ready.

  logic        adv1;
  logic        adv2;

  logic        s1_valid;
  logic [15:0] s1_lo;
  logic        s1_c16;
  logic [15:0] s1_ahi;
  logic [15:0] s1_bhi;
  logic        s1_a31;
  logic        s1_b31;

  logic        s2_valid;
  logic [31:0] s2_sum;
  logic        s2_co;
  logic        s2_ovf;

  logic [15:0] lo_sum;
  logic        lo_co;
  logic [15:0] hi_sum;
  logic        hi_co;
  logic        hi_ovf;

  assign adv2     = !s2_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  cla16 u_lo (
    .a  (a[15:0]),
    .b  (b[15:0]),
    .ci (ci),
    .s  (lo_sum),
    .co (lo_co)
  );

  cla16 u_hi (
    .a  (s1_ahi),
    .b  (s1_bhi),
    .ci (s1_c16),
    .s  (hi_sum),
    .co (hi_co)
  );

  assign hi_ovf = (s1_a31 == s1_b31) && (hi_sum[15] != s1_a31);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
    end
  end

  // Data loads only with a valid beat so idle X operands never reach the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_lo  <= '0;
      s1_c16 <= 1'b0;
      s1_ahi <= '0;
      s1_bhi <= '0;
      s1_a31 <= 1'b0;
      s1_b31 <= 1'b0;
    end else if (adv1 && in_valid) begin
      s1_lo  <= lo_sum;
      s1_c16 <= lo_co;
      s1_ahi <= a[31:16];
      s1_bhi <= b[31:16];
      s1_a31 <= a[31];
      s1_b31 <= b[31];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_sum <= '0;
      s2_co  <= 1'b0;
      s2_ovf <= 1'b0;
    end else if (adv2 && s1_valid) begin
      s2_sum <= {hi_sum, s1_lo};
      s2_co  <= hi_co;
      s2_ovf <= hi_ovf;
    end
  end

  assign out_valid = s2_valid;
  assign sum       = s2_sum;
  assign co        = s2_co;
  assign ovf       = s2_ovf;
endmodule

// File: tb/tb_cla32_pipe.sv
// Bench for cla32_pipe: directed vector table, streaming, backpressure,
// random stalls and mid-flight reset, all scored against an arithmetic model.

module tb_cla32_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        ci;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        co;
  logic        ovf;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] s;
    logic        co;
    logic        ovf;
  } vec_t;

  vec_t        vecs[9];
  logic [33:0] exp_q[$];
  int          checks  = 0;
  int          errors  = 0;
  int          accepts = 0;
  int          pops    = 0;
  logic        hold_prev = 1'b0;
  logic [33:0] hold_val  = '0;

  cla32_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
    .ovf       (ovf)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Reference: {ovf, co, sum} from plain 33-bit arithmetic.
  function automatic logic [33:0] ref_model(input logic [31:0] x, input logic [31:0] y,
                                            input logic c);
    logic [32:0] full;
    logic        v;
    full = {1'b0, x} + {1'b0, y} + {32'd0, c};
    v    = (x[31] == y[31]) && (full[31] != x[31]);
    return {v, full[32], full[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, expv, $time);
    end
  endtask

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    logic [33:0] e;
    if (rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev)
        chk("hold_stable", 64'({out_valid, ovf, co, sum}), 64'({1'b1, hold_val}));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("result", 64'({ovf, co, sum}), 64'(e));
          pops++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(a, b, ci));
        accepts++;
      end
      hold_prev = out_valid && !out_ready;
      hold_val  = {ovf, co, sum};
    end
  end

  // Driver helper: move to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [33:0] held_exp;
    logic        fired;
    int          p0;
    int          n;

    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    ci        = 1'b0;
    out_ready = 1'b1;

    vecs[0] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
    vecs[6] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0};
    vecs[7] = '{32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[8] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1};

    // Reset state
    #2;
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_sum", 64'(sum), 64'(0));
    chk("reset_co_ovf", 64'({co, ovf}), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(in_ready), 64'(1));

    // Directed vectors: one beat each, exact 2-cycle latency
    for (int i = 0; i < 9; i++) begin
      step();
      in_valid = 1'b1;
      a  = vecs[i].a;
      b  = vecs[i].b;
      ci = vecs[i].ci;
      step();
      in_valid = 1'b0;
      a  = $urandom;
      b  = $urandom;
      @(negedge clk);
      chk("vec_latency_early", 64'(out_valid), 64'(0));
      @(negedge clk);
      chk("vec_out_valid", 64'(out_valid), 64'(1));
      chk("vec_sum", 64'(sum), 64'(vecs[i].s));
      chk("vec_co", 64'(co), 64'(vecs[i].co));
      chk("vec_ovf", 64'(ovf), 64'(vecs[i].ovf));
    end

    // Streaming: 100 back-to-back beats
    for (int i = 0; i < 102; i++) begin
      step();
      in_valid = (i < 100);
      a  = $urandom;
      b  = $urandom;
      ci = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (i < 100) chk("stream_in_ready", 64'(in_ready), 64'(1));
      if (i >= 2)  chk("stream_out_valid", 64'(out_valid), 64'(1));
    end
    step();
    in_valid = 1'b0;

    // Backpressure: fill both stages, hold output for 5 cycles
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a  = $urandom;
    b  = $urandom;
    ci = 1'($urandom_range(0, 1));
    held_exp = ref_model(a, b, ci);
    @(negedge clk);
    chk("bp_ready_beat0", 64'(in_ready), 64'(1));
    step();
    a  = $urandom;
    b  = $urandom;
    ci = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("bp_ready_beat1", 64'(in_ready), 64'(1));
    step();
    a  = $urandom;
    b  = $urandom;
    ci = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("bp_ready_full", 64'(in_ready), 64'(0));
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk("bp_held_ready", 64'(in_ready), 64'(0));
      chk("bp_held_valid", 64'(out_valid), 64'(1));
      chk("bp_held_sum", 64'({ovf, co, sum}), 64'(held_exp));
    end
    p0 = pops;
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("bp_drain_count", 64'(pops - p0), 64'(3));

    // Random stalls: 50% in_valid, 50% out_ready
    fired = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      step();
      if (!in_valid || fired) begin
        in_valid = 1'($urandom_range(0, 1));
        a  = $urandom;
        b  = $urandom;
        ci = 1'($urandom_range(0, 1));
      end
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      fired = in_valid && in_ready;
    end
    step();
    in_valid  = 1'b0;
    chk("inflight_bound", 64'(exp_q.size() <= 2), 64'(1));
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    chk("accept_vs_pop", 64'(pops), 64'(accepts));

    // Reset with two beats in flight
    step();
    in_valid = 1'b1;
    a  = $urandom;
    b  = $urandom;
    step();
    a  = $urandom;
    b  = $urandom;
    step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
    chk("rst_mid_sum", 64'(sum), 64'(0));
    chk("rst_mid_co_ovf", 64'({co, ovf}), 64'(0));
    @(posedge clk);
    #2 rst = 1'b0;
    step();
    in_valid = 1'b1;
    a  = 32'd3;
    b  = 32'd4;
    ci = 1'b0;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_early", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 64'(1));
    chk("post_rst_sum", 64'(sum), 64'(7));
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cla32_pipe.md
Name: cla32_pipe

Overview:
- Two-stage pipelined 32-bit adder built from the team's cla4 blocks.
- Stage 1 adds the low 16 bits and registers the sum, the carry and the high operand halves.
- Stage 2 adds the high 16 bits, using the registered carry as carry-in.
- Sits between the operand source and the ALU result mux; valid/ready handshake on both sides, full throughput, fixed 2-cycle latency.

Parameters:
- None. Width fixed at 32 bits, split 16/16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts operand beat this cycle
- a  input  32  operand A
- b  input  32  operand B
- ci  input  1  carry-in to bit 0
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts result this cycle
- sum  output  32  registered a+b+ci, modulo 2^32
- co  output  1  carry out of bit 31
- ovf  output  1  two's-complement overflow: (a[31]==b[31]) && (sum[31]!=a[31])

Behaviour:
- Reset (async, rst=1): s1_valid=0, s2_valid=0, all data registers 0. Outputs during and after reset: out_valid=0, sum=0, co=0, ovf=0.
- in_ready=1 immediately after reset.
- Handshake rules:
  - Transfer happens when valid && ready on the same rising edge.
  - Producer holds a/b/ci stable while in_valid=1 && in_ready=0.
  - sum/co/ovf are held stable while out_valid=1 && out_ready=0.
- Stage advance:
  - adv2 = !s2_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1, purely combinational from registered state and out_ready; no path from in_valid.
- Stage 1, on an adv1 edge:
  - s1_valid <= in_valid.
  - If in_valid: s1_lo <= a[15:0]+b[15:0]+ci and s1_c16 <= carry out of bit 15.
  - The low sum uses four cla4 blocks with group lookahead on PG/GG, not ripple.
  - a[31:16], b[31:16] and sign bits a[31], b[31] are registered unchanged.
- Stage 2, on an adv2 edge:
  - s2_valid <= s1_valid.
  - If s1_valid: sum <= {hi_add, s1_lo}, where hi_add = s1_ahi+s1_bhi+s1_c16, also from four cla4 blocks.
  - co <= carry out of bit 31; ovf computed from the registered sign bits and sum[31].
- Latency: an accepted beat appears at out_valid exactly 2 cycles later if out_ready stays high.
- Throughput: 1 beat/cycle.
- Backpressure:
  - out_ready=0 with both stages full: in_ready=0, nothing moves, no beat dropped or duplicated.
  - out_ready=0 with stage 2 full and stage 1 empty: stage 1 still accepts one beat, then in_ready drops.
- Simultaneous events:
  - Output handshake and input handshake on the same edge both occur; the pipeline shifts by one.
  - Bubbles (in_valid=0) propagate as s*_valid=0; data registers may hold stale values, which is allowed.
- Wrap-around: results are modulo 2^32. 0xFFFFFFFF+1 gives sum=0, co=1, ovf=0.
- Reset mid-operation: in-flight beats are discarded and out_valid drops asynchronously. The first beat after rst deasserts gets normal 2-cycle latency.
- No X propagation on outputs when in_valid=0 with X operands: data registers load only when the corresponding valid is 1.

Test Plan:
- Basic add: a=0x0000_FFFF, b=0x0000_0001, ci=0, out_ready=1 -> 2 cycles later sum=0x0001_0000, co=0, ovf=0 (checks carry across the stage boundary).
- Carry/overflow: a=0xFFFF_FFFF, b=0x0000_0000, ci=1 -> sum=0, co=1, ovf=0. a=0x7FFF_FFFF, b=1, ci=0 -> sum=0x8000_0000, co=0, ovf=1.
- Streaming: 100 back-to-back random beats, out_ready=1 -> in_ready stays 1 and out_valid is high every cycle from cycle 2. Results match the reference model in order.
- Backpressure: fill the pipe, then hold out_ready=0 for 5 cycles.
  - in_ready=0 after the second held beat.
  - sum stays stable while held.
  - On release, beats drain in order with none lost or duplicated.
- Random stall: random in_valid and out_ready at 50% each for 10k cycles -> scoreboard shows exact in-order match, and the sum count equals the accept count minus the beats still in flight.
- Reset mid-flight: assert rst asynchronously (between clock edges) with 2 beats in flight -> out_valid=0 and sum=0 immediately. After release, the beat a=3, b=4, ci=0 gives sum=7 after 2 cycles.
